adc_acq_arbiter: RTL and testbench



---
 rtl/adc_acq_pkg.sv | 34 +++
 rtl/adc_acq_arbiter_if.sv | 32 +++
 rtl/adc_rr_arbiter2.sv | 30 +++
 rtl/adc_acq_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_adc_acq_arbiter.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/adc_acq_pkg.sv
// Shared definitions for the AD9220 acquisition arbiter.
// Holds state codes, Data word layout and default timing values.
package adc_acq_pkg;

    localparam int ST_IDLE    = 0;
    localparam int ST_SETTLE  = 1;
    localparam int ST_ACQ     = 2;
    localparam int ST_DRAIN   = 3;
    localparam int ST_RELEASE = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'(ST_IDLE),
        S_SETTLE  = 3'(ST_SETTLE),
        S_ACQ     = 3'(ST_ACQ),
        S_DRAIN   = 3'(ST_DRAIN),
        S_RELEASE = 3'(ST_RELEASE)
    } state_e;

    localparam int DATA_OWNER   = 15;
    localparam int DATA_LAST    = 14;
    localparam int DATA_ABORT   = 13;
    localparam int DATA_OTR     = 12;
    localparam int DATA_SMP_MSB = 11;
    localparam int DATA_SMP_LSB = 0;

    localparam int DEF_START_DELAY  = 4;
    localparam int DEF_FLUSH_CYCLES = 16;
    localparam int DEF_TIMEOUT      = 1023;

    function automatic logic [1:0] owner_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/adc_acq_arbiter_if.sv
// Bundle of requester, ADC driver and readout FIFO signals.
// master: the arbiter; slave: requesters, ADC driver and FIFO side.
interface adc_acq_arbiter_if;

    logic [1:0]  Req;
    logic [7:0]  NumSamples0;
    logic [7:0]  NumSamples1;
    logic [1:0]  Grant;
    logic [1:0]  Done;
    logic        Abort;
    logic        AdcStart;
    logic        AdcData_en;
    logic [11:0] AdcData;
    logic        AdcOtr;
    logic [15:0] Data;
    logic        Data_en;

    modport master (
        input  Req, NumSamples0, NumSamples1,
        input  AdcData_en, AdcData, AdcOtr,
        output Grant, Done, Abort, AdcStart,
        output Data, Data_en
    );

    modport slave (
        output Req, NumSamples0, NumSamples1,
        output AdcData_en, AdcData, AdcOtr,
        input  Grant, Done, Abort, AdcStart,
        input  Data, Data_en
    );

endinterface

// File: rtl/adc_rr_arbiter2.sv
// Two-way round-robin selector with a pointer register.
// Ports: clk_i, rst_i, req_i[1:0], advance_i -> sel_o, valid_o.
module adc_rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic       sel_o,
    output logic       valid_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        ptr_d   = advance_i ? ~ptr_q : ptr_q;
        valid_o = |req_i;
        // Pointer wins a tie; otherwise the only requester wins.
        sel_o   = req_i[ptr_q] ? ptr_q : ~ptr_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/adc_acq_arbiter.sv
// Shares one AD9220 acquisition path between two requesters.
// Ports: Clk, reset, bus (Req/NumSamples in, Grant/Done/Abort/ADC/Data).
module adc_acq_arbiter
    import adc_acq_pkg::*;
#(
    parameter int START_DELAY  = DEF_START_DELAY,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int TIMEOUT      = DEF_TIMEOUT
) (
    input  logic              Clk,
    input  logic              reset,
    adc_acq_arbiter_if.master bus
);

    // One timer serves settle, watchdog and flush counting.
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(START_DELAY - 1);
    localparam logic [TW-1:0] FLUSH_LAST  = TW'(FLUSH_CYCLES - 1);
    localparam logic [TW-1:0] WD_LAST     = TW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic          owner_q, owner_d;
    logic [7:0]    nsamp_q, nsamp_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          abort_q, abort_d;
    logic [1:0]    grant_q, grant_d;
    logic [1:0]    done_q, done_d;
    logic          abt_q, abt_d;
    logic          start_q, start_d;
    logic [15:0]   data_q, data_d;
    logic          den_q, den_d;

    logic rr_sel;
    logic rr_valid;
    logic rr_adv;
    logic own_req;
    logic last;

    assign rr_adv  = (state_q == S_RELEASE);
    assign own_req = bus.Req[owner_q];
    assign last    = ((cnt_q + 8'd1) == nsamp_q);

    adc_rr_arbiter2 u_rr (
        .clk_i     (Clk),
        .rst_i     (reset),
        .req_i     (bus.Req),
        .advance_i (rr_adv),
        .sel_o     (rr_sel),
        .valid_o   (rr_valid)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        nsamp_d = nsamp_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        abort_d = abort_q;
        grant_d = grant_q;
        done_d  = 2'b00;
        abt_d   = 1'b0;
        start_d = start_q;
        data_d  = data_q;
        den_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (rr_valid) begin
                    owner_d = rr_sel;
                    nsamp_d = rr_sel ? bus.NumSamples1 : bus.NumSamples0;
                    grant_d = owner_onehot(rr_sel);
                    cnt_d   = '0;
                    tmr_d   = '0;
                    abort_d = 1'b0;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (!own_req) begin
                    abort_d = 1'b1;
                    done_d  = grant_q;
                    abt_d   = 1'b1;
                    state_d = S_RELEASE;
                end else if (tmr_q == SETTLE_LAST) begin
                    tmr_d = '0;
                    if (nsamp_q == 8'd0) begin
                        done_d  = grant_q;
                        abt_d   = 1'b0;
                        state_d = S_RELEASE;
                    end else begin
                        start_d = 1'b1;
                        state_d = S_ACQ;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_ACQ: begin
                // A pulse coinciding with the Req drop is discarded.
                if (!own_req) begin
                    start_d = 1'b0;
                    abort_d = 1'b1;
                    tmr_d   = '0;
                    state_d = S_DRAIN;
                end else if (bus.AdcData_en) begin
                    cnt_d  = cnt_q + 8'd1;
                    tmr_d  = '0;
                    den_d  = 1'b1;
                    data_d = '0;
                    data_d[DATA_OWNER] = owner_q;
                    data_d[DATA_LAST]  = last;
                    data_d[DATA_ABORT] = 1'b0;
                    data_d[DATA_OTR]   = bus.AdcOtr;
                    data_d[DATA_SMP_MSB:DATA_SMP_LSB] = bus.AdcData;
                    if (last) begin
                        start_d = 1'b0;
                        state_d = S_DRAIN;
                    end
                end else if (tmr_q == WD_LAST) begin
                    start_d = 1'b0;
                    abort_d = 1'b1;
                    tmr_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // Samples still in the ADC pipeline are dropped here.
                if (tmr_q == FLUSH_LAST) begin
                    tmr_d   = '0;
                    done_d  = grant_q;
                    abt_d   = abort_q;
                    state_d = S_RELEASE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_RELEASE: begin
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
                start_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            nsamp_q <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            abort_q <= 1'b0;
            grant_q <= '0;
            done_q  <= '0;
            abt_q   <= 1'b0;
            start_q <= 1'b0;
            data_q  <= '0;
            den_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            nsamp_q <= nsamp_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            abort_q <= abort_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            abt_q   <= abt_d;
            start_q <= start_d;
            data_q  <= data_d;
            den_q   <= den_d;
        end
    end

    assign bus.Grant    = grant_q;
    assign bus.Done     = done_q;
    assign bus.Abort    = abt_q;
    assign bus.AdcStart = start_q;
    assign bus.Data     = data_q;
    assign bus.Data_en  = den_q;

endmodule

// File: tb/tb_adc_acq_arbiter.sv
// Directed bench for adc_acq_arbiter.
// Cycle 0 of each transaction is the IDLE cycle in which Req is raised.
module tb_adc_acq_arbiter;

    logic Clk;
    logic reset;
    int   total;
    int   bad;

    adc_acq_arbiter_if b ();

    adc_acq_arbiter dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (b)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string       nm;
        int          own;
        int          ns;
        int          npulse;
        int          gap;
        logic [11:0] base;
        int          drop;
        int          exp_den;
        logic        exp_abort;
        int          exp_start;
        int          exp_fall;
        int          exp_done;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Runs one grant to completion, feeding a pulse every gap cycles
    // once AdcStart is seen; Req[own] is dropped at pulse index drop
    // (that pulse is still sent) and cleared when Done arrives.
    task automatic serve(input string nm, input int own, input int ns,
                         input int npulse, input int gap,
                         input logic [11:0] base, input int drop,
                         input int exp_den, input logic exp_abort,
                         input int exp_start, input int exp_fall,
                         input int exp_done);
        int          g_cyc, s_cyc, f_cyc, d_cyc;
        int          nden, k, nextp;
        logic [1:0]  oh, dval;
        logic        aval;
        logic [11:0] smp;
        logic [15:0] expw;
        oh = (own == 1) ? 2'b10 : 2'b01;
        g_cyc = -1; s_cyc = -1; f_cyc = -1; d_cyc = -1;
        nden = 0; k = 0; nextp = -1;
        dval = 2'b00; aval = 1'b0;
        for (int c = 1; c <= 1200 && d_cyc < 0; c++) begin
            tick();
            b.AdcData_en = 1'b0;
            if (g_cyc < 0 && b.Grant == oh) g_cyc = c;
            if (s_cyc < 0 && b.AdcStart) begin
                s_cyc = c;
                nextp = c + 1;
            end
            if (s_cyc >= 0 && f_cyc < 0 && !b.AdcStart) f_cyc = c;
            if (b.Data_en) begin
                smp  = base + nden[11:0];
                expw = {oh[1], (nden + 1 == ns), 1'b0, nden[0], smp};
                chk({nm, "_word"}, {16'h0, b.Data}, {16'h0, expw});
                nden++;
            end
            if (b.Done != 2'b00) begin
                d_cyc = c;
                dval  = b.Done;
                aval  = b.Abort;
                b.Req[own] = 1'b0;
            end else if (c == nextp && k < npulse) begin
                if (k == drop) b.Req[own] = 1'b0;
                b.AdcData_en = 1'b1;
                b.AdcData    = base + k[11:0];
                b.AdcOtr     = k[0];
                k++;
                nextp += gap;
            end
        end
        b.AdcData_en = 1'b0;
        chk({nm, "_grant_cyc"}, g_cyc, 1);
        chk({nm, "_start_cyc"}, s_cyc, exp_start);
        chk({nm, "_fall_cyc"}, f_cyc, exp_fall);
        chk({nm, "_den_cnt"}, nden, exp_den);
        chk({nm, "_done_cyc"}, d_cyc, exp_done);
        chk({nm, "_done_val"}, {30'h0, dval}, {30'h0, oh});
        chk({nm, "_abort"}, {31'h0, aval}, {31'h0, exp_abort});
    endtask

    initial begin
        logic found;
        total = 0;
        bad   = 0;
        b.Req = 2'b00;
        b.NumSamples0 = 8'd0;
        b.NumSamples1 = 8'd0;
        b.AdcData_en  = 1'b0;
        b.AdcData     = 12'h000;
        b.AdcOtr      = 1'b0;

        // name own ns np gap base drop den abort start fall done
        vecs[0] = '{"single", 0, 5, 5, 4, 12'h100, -1, 5, 1'b0, 5, 23, 39};
        vecs[1] = '{"drop", 0, 8, 8, 4, 12'h200, 2, 2, 1'b1, 5, 15, 31};
        vecs[2] = '{"zero", 1, 0, 0, 4, 12'h000, -1, 0, 1'b0, -1, -1, 5};
        vecs[3] = '{"drain", 1, 3, 5, 3, 12'hA00, -1, 3, 1'b0, 5, 13, 29};
        vecs[4] = '{"tmo", 0, 4, 0, 4, 12'h000, -1, 0, 1'b1, 5, 1028, 1044};

        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_grant", {30'h0, b.Grant}, 32'h0);
        chk("rst_done", {30'h0, b.Done}, 32'h0);
        chk("rst_abort", {31'h0, b.Abort}, 32'h0);
        chk("rst_start", {31'h0, b.AdcStart}, 32'h0);
        chk("rst_data", {16'h0, b.Data}, 32'h0);
        chk("rst_den", {31'h0, b.Data_en}, 32'h0);

        // Simultaneous requests from reset: pointer favours 0 first.
        b.NumSamples0 = 8'd2;
        b.NumSamples1 = 8'd3;
        b.Req = 2'b11;
        serve("rr0", 0, 2, 2, 4, 12'h300, -1, 2, 1'b0, 5, 11, 27);
        tick();
        serve("rr1", 1, 3, 3, 4, 12'h400, -1, 3, 1'b0, 5, 15, 31);

        foreach (vecs[i]) begin
            tick();
            if (vecs[i].own == 1) begin
                b.NumSamples1 = vecs[i].ns[7:0];
                b.Req = 2'b10;
            end else begin
                b.NumSamples0 = vecs[i].ns[7:0];
                b.Req = 2'b01;
            end
            serve(vecs[i].nm, vecs[i].own, vecs[i].ns, vecs[i].npulse,
                  vecs[i].gap, vecs[i].base, vecs[i].drop,
                  vecs[i].exp_den, vecs[i].exp_abort,
                  vecs[i].exp_start, vecs[i].exp_fall,
                  vecs[i].exp_done);
        end

        // Seven releases so far leave the pointer on requester 1;
        // reset must bring it back to requester 0.
        tick();
        b.NumSamples1 = 8'd5;
        b.Req = 2'b10;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (b.AdcStart) found = 1'b1;
        end
        chk("mid_start_seen", {31'h0, found}, 32'h1);
        b.AdcData_en = 1'b1;
        b.AdcData    = 12'h5A5;
        b.AdcOtr     = 1'b0;
        tick();
        b.AdcData_en = 1'b0;
        chk("mid_den", {31'h0, b.Data_en}, 32'h1);
        chk("mid_data", {16'h0, b.Data}, 32'h85A5);
        tick();
        reset = 1'b1;
        b.NumSamples0 = 8'd3;
        b.Req = 2'b11;
        tick();
        chk("mrst_grant", {30'h0, b.Grant}, 32'h0);
        chk("mrst_start", {31'h0, b.AdcStart}, 32'h0);
        chk("mrst_data", {16'h0, b.Data}, 32'h0);
        chk("mrst_done", {30'h0, b.Done}, 32'h0);
        chk("mrst_den", {31'h0, b.Data_en}, 32'h0);
        reset = 1'b0;
        tick();
        chk("post_grant", {30'h0, b.Grant}, 32'h1);
        chk("post_done", {30'h0, b.Done}, 32'h0);
        // Withdraw during SETTLE: aborted release, ADC never started.
        b.Req = 2'b00;
        tick();
        chk("wd_done", {30'h0, b.Done}, 32'h1);
        chk("wd_abort", {31'h0, b.Abort}, 32'h1);
        chk("wd_start", {31'h0, b.AdcStart}, 32'h0);
        tick();
        chk("wd_grant_clr", {30'h0, b.Grant}, 32'h0);
        chk("wd_done_clr", {30'h0, b.Done}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
